cpu_boot_loader: RTL and testbench

Byte-stream boot loader that fills the CPU's instruction memory and data memory from a host link, then releases the pipeline by asserting `start`. It sits between the host interface (UART/JTAG byte bridge) and the `CPU` top. It replaces the simulation-only preload and start sequence: instruction words into `Instruction_Memory.memory`, input operands into `dm.mem`, then `start_i` raised.

---
 rtl/cpu_boot_loader_if.sv | 31 +++
 rtl/cpu_boot_loader.sv | 111 +++++++++++
 tb/tb_cpu_boot_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_boot_loader_if.sv
// Host byte stream plus instruction/data memory write port and status of the boot loader.
// slave = loader side, master = host/CPU side.
interface cpu_boot_loader_if #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 5
);
  logic               rx_valid_i;
  logic [7:0]         rx_data_i;
  logic               rx_ready_o;
  logic               imem_we_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_data_o;
  logic               dmem_we_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [7:0]         dmem_data_o;
  logic               start_o;
  logic               busy_o;
  logic               err_o;

  modport slave (
    input  rx_valid_i, rx_data_i,
    output rx_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o, start_o, busy_o, err_o
  );

  modport master (
    output rx_valid_i, rx_data_i,
    input  rx_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o, start_o, busy_o, err_o
  );
endinterface

// File: rtl/cpu_boot_loader.sv
// Byte-stream boot loader: CMD/ADDR/COUNT/payload frames fill IMEM words and DMEM bytes,
// GO releases the CPU via a sticky start.
module cpu_boot_loader #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  cpu_boot_loader_if.slave  bus
);
  localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          imem_q, imem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   word_q, word_d;
  logic          err_q, err_d;
  logic          accept;

  assign bus.rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                          (state_q == S_COUNT) || (state_q == S_DATA);
  assign accept = bus.rx_valid_i && bus.rx_ready_o;

  always_comb begin
    state_d = state_q;
    imem_d  = imem_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        case (bus.rx_data_i)
          8'h01:   begin state_d = S_ADDR; imem_d = 1'b1; end
          8'h02:   begin state_d = S_ADDR; imem_d = 1'b0; end
          8'hFF:   state_d = S_RUN;
          8'h00:   ;
          default: err_d = 1'b1;
        endcase
      end
      S_ADDR: if (accept) begin
        addr_d  = AW'(bus.rx_data_i);
        state_d = S_COUNT;
      end
      S_COUNT: if (accept) begin
        cnt_d   = (bus.rx_data_i == 8'd0) ? 9'd256 : {1'b0, bus.rx_data_i};
        byte_d  = 2'd0;
        state_d = S_DATA;
      end
      S_DATA: if (accept) begin
        // Little-endian: bytes shift in from the top, so the first lands in bits 7:0
        // after four bytes; a DMEM byte sits in bits 31:24.
        word_d = {bus.rx_data_i, word_q[31:8]};
        if (!imem_q || byte_q == 2'd3) begin
          byte_d  = 2'd0;
          state_d = S_WRITE;
        end else begin
          byte_d = byte_q + 2'd1;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + AW'(1);
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? S_IDLE : S_DATA;
      end
      S_RUN:   ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      imem_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      imem_q  <= imem_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_we_o   = (state_q == S_WRITE) && imem_q;
  assign bus.dmem_we_o   = (state_q == S_WRITE) && !imem_q;
  assign bus.imem_addr_o = addr_q[IMEM_AW-1:0];
  assign bus.dmem_addr_o = addr_q[DMEM_AW-1:0];
  assign bus.imem_data_o = word_q;
  assign bus.dmem_data_o = word_q[31:24];
  assign bus.start_o     = (state_q == S_RUN);
  assign bus.busy_o      = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                           (state_q == S_DATA) || (state_q == S_WRITE);
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_cpu_boot_loader.sv
// Scoreboard bench for cpu_boot_loader: expected memory writes are queued as frames are
// sent and popped by a write monitor.
module tb_cpu_boot_loader;
  typedef struct {
    logic        imem;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_wr = 0;
  wr_t  sb[$];
  logic [7:0] tx[$];

  cpu_boot_loader_if #(.IMEM_AW(8), .DMEM_AW(5)) bus ();
  cpu_boot_loader #(.IMEM_AW(8), .DMEM_AW(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && (bus.imem_we_o || bus.dmem_we_o)) begin
      wr_t e;
      n_wr++;
      chk("rdy_in_write", 32'(bus.rx_ready_o), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_kind", 32'(bus.imem_we_o), 32'(e.imem));
        chk("wr_both", 32'(bus.imem_we_o && bus.dmem_we_o), 32'd0);
        if (bus.imem_we_o) begin
          chk("imem_addr", 32'(bus.imem_addr_o), e.addr);
          chk("imem_data", bus.imem_data_o, e.data);
        end else begin
          chk("dmem_addr", 32'(bus.dmem_addr_o), e.addr);
          chk("dmem_data", 32'(bus.dmem_data_o), e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit rdy;
    int n;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    for (int t = 0; t <= 64; t++) begin
      rdy = bus.rx_ready_o;
      cyc();
      if (rdy) break;
      if (t == 64) chk("accept_timeout", 32'd0, 32'd1);
    end
    if (gaps) begin
      n = $urandom_range(0, 2);
      if (n > 0) begin
        bus.rx_valid_i = 1'b0;
        repeat (n) cyc();
      end
    end
  endtask

  task automatic send_tx(input bit gaps);
    while (tx.size() > 0) send_byte(tx.pop_front(), gaps);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 50; t++) begin
      if (!bus.busy_o) break;
      cyc();
    end
    chk(tag, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rdy"},   32'(bus.rx_ready_o), 32'd1);
    chk({tag, "_start"}, 32'(bus.start_o), 32'd0);
    chk({tag, "_err"},   32'(bus.err_o), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy_o), 32'd0);
    chk({tag, "_iwe"},   32'(bus.imem_we_o), 32'd0);
    chk({tag, "_dwe"},   32'(bus.dmem_we_o), 32'd0);
    chk({tag, "_iaddr"}, 32'(bus.imem_addr_o), 32'd0);
    chk({tag, "_idata"}, bus.imem_data_o, 32'd0);
    chk({tag, "_daddr"}, 32'(bus.dmem_addr_o), 32'd0);
    chk({tag, "_ddata"}, 32'(bus.dmem_data_o), 32'd0);
  endtask

  // Queue an IMEM frame of cnt words (0 = 256) with random payload and its expected writes.
  task automatic imem_frame(input logic [7:0] addr, input logic [7:0] cnt);
    int items;
    logic [31:0] w;
    items = (cnt == 8'd0) ? 256 : int'(cnt);
    tx.push_back(8'h01); tx.push_back(addr); tx.push_back(cnt);
    for (int i = 0; i < items; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) tx.push_back(w[8*k +: 8]);
      sb.push_back('{1'b1, 32'((addr + 8'(i)) & 8'hFF), w});
    end
  endtask

  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (3) cyc();
    rst = 1'b0;
    check_reset_state("reset");

    // IMEM load, two words back to back
    n_wr = 0;
    tx = '{8'h01, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sb.push_back('{1'b1, 32'h0, 32'h12345678});
    sb.push_back('{1'b1, 32'h1, 32'hDEADBEEF});
    send_tx(1'b0);
    wait_idle("imem_idle");
    cyc();
    chk("imem_pulses", 32'(n_wr), 32'd2);
    chk("imem_sb_empty", 32'(sb.size()), 32'd0);

    // DMEM with address wrap and ignored upper address bits
    tx = '{8'h02, 8'h3F, 8'h02, 8'h05, 8'h07};
    sb.push_back('{1'b0, 32'd31, 32'h05});
    sb.push_back('{1'b0, 32'd0, 32'h07});
    send_tx(1'b0);
    wait_idle("dmem_idle");
    cyc();
    chk("dmem_sb_empty", 32'(sb.size()), 32'd0);

    // Count 0 means 256 words, address wraps 0xFF -> 0x00
    n_wr = 0;
    imem_frame(8'h10, 8'h00);
    send_tx(1'b0);
    wait_idle("cnt0_idle");
    cyc();
    chk("cnt0_pulses", 32'(n_wr), 32'd256);
    chk("cnt0_sb_empty", 32'(sb.size()), 32'd0);

    // Random valid gaps during an IMEM load
    imem_frame(8'hF8, 8'd12);
    send_tx(1'b1);
    wait_idle("bp_idle");
    cyc();
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Bad command, then a DMEM write, then GO
    tx = '{8'h33};
    send_tx(1'b0);
    chk("err_set", 32'(bus.err_o), 32'd1);
    chk("err_idle", 32'(bus.busy_o), 32'd0);
    tx = '{8'h02, 8'h00, 8'h01, 8'h05};
    sb.push_back('{1'b0, 32'd0, 32'h05});
    send_tx(1'b0);
    wait_idle("err_dmem_idle");
    cyc();
    chk("err_dmem_sb", 32'(sb.size()), 32'd0);
    chk("start_before_go", 32'(bus.start_o), 32'd0);
    tx = '{8'hFF};
    send_tx(1'b0);
    chk("start_after_go", 32'(bus.start_o), 32'd1);
    chk("rdy_after_go", 32'(bus.rx_ready_o), 32'd0);
    n_wr = 0;
    bus.rx_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.rx_data_i = (i % 2 == 0) ? 8'h01 : 8'h02;
      cyc();
    end
    bus.rx_valid_i = 1'b0;
    chk("run_rdy", 32'(bus.rx_ready_o), 32'd0);
    chk("run_start", 32'(bus.start_o), 32'd1);
    chk("run_err", 32'(bus.err_o), 32'd1);
    chk("run_no_wr", 32'(n_wr), 32'd0);

    // Reset mid-word must drop the partial item
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("rst_run");
    n_wr = 0;
    tx = '{8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send_tx(1'b0);
    chk("mid_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("rst_mid");
    repeat (3) cyc();
    chk("mid_no_wr", 32'(n_wr), 32'd0);
    tx = '{8'h01, 8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    sb.push_back('{1'b1, 32'd5, 32'h44332211});
    send_tx(1'b0);
    wait_idle("post_rst_idle");
    cyc();
    chk("post_rst_pulses", 32'(n_wr), 32'd1);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
